// File: rtl/mem_arbiter.sv
// Sequencer and arbiter for the shared program/data BRAM: LOAD / RUN / HALTED
// phases, round-robin CPU/host arbitration in RUN, and tagged read return.
module mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          cpu_halt,
    output logic          cpu_run,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          host_start,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic [1:0]    state,
    output logic [15:0]   run_cycles
);

    // state   | meaning
    // S_LOAD  | host loads program, CPU held in reset
    // S_RUN   | CPU executes, host interleaved round-robin
    // S_HALTED| CPU held again, host reads results
    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   run_q;
    logic   last_cpu_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [RD_LAT-1:0] pipe_cpu_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic [15:0]   run_cycles_q;

    logic cpu_eff, host_eff, any_gnt, rd_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == S_RUN);
        end
    end

    // halt takes priority over start because start is not looked at in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   if (host_start) state_d = S_RUN;
            S_RUN:    if (cpu_halt)   state_d = S_HALTED;
            S_HALTED: if (host_start) state_d = S_RUN;
            default:  state_d = S_LOAD;
        endcase
    end

    assign state   = state_q;
    assign cpu_run = run_q;

    // grants are forced low while reset is asserted
    assign cpu_eff  = cpu_req && (state_q == S_RUN) && !rst;
    assign host_eff = host_req && !rst;
    assign cpu_gnt  = cpu_eff && (!host_eff || !last_cpu_q);
    assign host_gnt = host_eff && !cpu_gnt;
    assign any_gnt  = cpu_gnt || host_gnt;

    always_comb begin
        mem_addr = addr_q;
        mem_din  = din_q;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end else if (host_gnt) begin
            mem_addr = host_addr;
            mem_din  = host_wdata;
        end
    end

    assign mem_we  = (cpu_gnt && cpu_we) || (host_gnt && host_we);
    assign rd_push = (cpu_gnt && !cpu_we) || (host_gnt && !host_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            din_q      <= '0;
            last_cpu_q <= 1'b0;
        end else if (any_gnt) begin
            addr_q     <= mem_addr;
            din_q      <= mem_din;
            last_cpu_q <= cpu_gnt;
        end
    end

    // owner-tag pipeline lines up with the BRAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_cpu_q <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_cpu_q[i] <= pipe_cpu_q[i-1];
            end
            pipe_vld_q[0] <= rd_push;
            pipe_cpu_q[0] <= cpu_gnt;
        end
    end

    assign cpu_rvalid  = pipe_vld_q[RD_LAT-1] && pipe_cpu_q[RD_LAT-1];
    assign host_rvalid = pipe_vld_q[RD_LAT-1] && !pipe_cpu_q[RD_LAT-1];
    assign cpu_rdata   = cpu_rvalid  ? mem_dout : cpu_rdata_q;
    assign host_rdata  = host_rvalid ? mem_dout : host_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            cpu_rdata_q  <= cpu_rdata;
            host_rdata_q <= host_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles_q <= '0;
        end else if (state_q != S_RUN && state_d == S_RUN) begin
            run_cycles_q <= '0;
        end else if (state_q == S_RUN && run_cycles_q != 16'hFFFF) begin
            run_cycles_q <= run_cycles_q + 16'd1;
        end
    end

    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed phases plus random RUN traffic, checked
// against a queue-based reference of the arbitration and read-return rules.
module tb_mem_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, cpu_halt = 0;
    logic [7:0]  cpu_addr = 0;
    logic [15:0] cpu_wdata = 0;
    logic        host_req = 0, host_we = 0, host_start = 0;
    logic [7:0]  host_addr = 0;
    logic [15:0] host_wdata = 0;
    logic        cpu_gnt, cpu_rvalid, cpu_run, host_gnt, host_rvalid, mem_we;
    logic [15:0] cpu_rdata, host_rdata, mem_din, mem_dout, run_cycles;
    logic [7:0]  mem_addr;
    logic [1:0]  state;

    mem_arbiter #(.AW(8), .DW(16), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_halt(cpu_halt), .cpu_run(cpu_run),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_start(host_start),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .state(state), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // BRAM with two-cycle read latency
    logic [15:0] ram [256];
    logic [15:0] ram_d1, ram_d2;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        ram_d1 <= ram[mem_addr];
        ram_d2 <= ram_d1;
    end
    assign mem_dout = ram_d2;

    // reference model
    typedef struct {
        int          due;
        bit          cpu;
        logic [15:0] data;
    } rd_t;
    rd_t         rq[$];
    logic [15:0] m_mem [256];
    int          m_state, m_rc, cyc;
    bit          m_last_cpu, rst_lvl;
    logic [7:0]  m_addr;
    logic [15:0] m_din, m_cpu_rdata, m_host_rdata;
    logic        obs_cpu_gnt;
    logic [7:0]  obs_addr;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_rc = 0; m_last_cpu = 0;
        m_addr = 0; m_din = 0; m_cpu_rdata = 0; m_host_rdata = 0;
        rq.delete();
    endtask

    task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                        input logic hr, input logic hw, input logic [7:0] ha, input logic [15:0] hd,
                        input logic st, input logic hl);
        bit gc, gh, ret, ret_cpu;
        logic [7:0]  ea;
        logic [15:0] ed;
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        host_start = st; cpu_halt = hl; rst = rst_lvl;
        if (rst_lvl) model_reset();
        gc = 0; gh = 0;
        if (!rst_lvl) begin
            gc = cr && (m_state == 1) && (!hr || !m_last_cpu);
            gh = hr && !gc;
        end
        ea = gc ? ca : (gh ? ha : m_addr);
        ed = gc ? cd : (gh ? hd : m_din);
        ret = (rq.size() > 0) && (rq[0].due == cyc);
        ret_cpu = ret && rq[0].cpu;
        if (ret) begin
            if (rq[0].cpu) m_cpu_rdata = rq[0].data;
            else           m_host_rdata = rq[0].data;
        end
        #1;
        chk("cpu_gnt",     32'(cpu_gnt),     32'(gc));
        chk("host_gnt",    32'(host_gnt),    32'(gh));
        chk("mem_we",      32'(mem_we),      32'((gc && cw) || (gh && hw)));
        chk("mem_addr",    32'(mem_addr),    32'(ea));
        chk("mem_din",     32'(mem_din),     32'(ed));
        chk("cpu_rvalid",  32'(cpu_rvalid),  32'(ret_cpu));
        chk("host_rvalid", 32'(host_rvalid), 32'(ret && !ret_cpu));
        chk("cpu_rdata",   32'(cpu_rdata),   32'(m_cpu_rdata));
        chk("host_rdata",  32'(host_rdata),  32'(m_host_rdata));
        chk("state",       32'(state),       32'(m_state));
        chk("cpu_run",     32'(cpu_run),     32'(m_state == 1));
        chk("run_cycles",  32'(run_cycles),  32'(m_rc));
        obs_cpu_gnt = cpu_gnt;
        obs_addr = mem_addr;
        @(posedge clk);
        if (!rst_lvl) begin
            if (ret) void'(rq.pop_front());
            if (gc || gh) begin
                m_last_cpu = gc;
                m_addr = ea;
                m_din = ed;
                if ((gc && cw) || (gh && hw)) m_mem[ea] = ed;
                else rq.push_back('{cyc + RD_LAT, gc, m_mem[ea]});
            end
            if (m_state == 1) begin
                if (m_rc < 65535) m_rc++;
                if (hl) m_state = 2;
            end else if (st) begin
                m_state = 1;
                m_rc = 0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, 0);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [15:0] d);
        step(1, 0, 8'($urandom), 16'($urandom), 1, 1, a, d, 0, 0);
    endtask

    task automatic host_rd(input logic [7:0] a);
        step(1, 0, 8'($urandom), 16'($urandom), 1, 0, a, 16'($urandom), 0, 0);
    endtask

    task automatic rand_step(input logic hl);
        step(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
             1'($urandom_range(0, 7) == 0), hl);
    endtask

    initial begin
        cyc = 0;
        rst_lvl = 1;
        model_reset();
        idle(2);
        rst_lvl = 0;

        // load every address so all later reads have known contents
        for (int i = 0; i < 256; i++) host_wr(8'(i), 16'($urandom));

        // LOAD phase
        host_wr(8'd0, 16'h0232);
        host_wr(8'd50, 16'h0001);
        host_rd(8'd50);
        idle(1);
        #1;
        chk("t1_host_rvalid", 32'(host_rvalid), 32'd1);
        chk("t1_host_rdata",  32'(host_rdata),  32'h0001);
        idle(2);

        // start, run 40 cycles, halt
        step(0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 1, 0);
        #1;
        chk("t2_cpu_run_up", 32'(cpu_run), 32'd1);
        for (int i = 0; i < 39; i++) rand_step(0);
        rand_step(1);
        idle(4);
        chk("t2_state",      32'(state),      32'd2);
        chk("t2_cpu_run",    32'(cpu_run),    32'd0);
        chk("t2_run_cycles", 32'(run_cycles), 32'd40);

        // HALTED: host reads, cpu_req ignored
        host_rd(8'd0);
        host_rd(8'd50);
        idle(3);
        step(0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 1, 0);

        // RUN conflict: CPU, HOST, CPU, HOST
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'd10, 16'h0, 1, 0, 8'd20, 16'h0, 0, 0);
            chk("t3_order", 32'(obs_cpu_gnt), 32'((i % 2) == 0));
            chk("t3_addr",  32'(obs_addr),    (i % 2) == 0 ? 32'd10 : 32'd20);
        end
        idle(3);

        for (int i = 0; i < 300; i++) rand_step(0);
        idle(3);

        // start and halt together in RUN, then restart from HALTED
        step(0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 1, 1);
        #1;
        chk("t4_state_halted", 32'(state), 32'd2);
        idle(2);
        step(0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 1, 0);
        #1;
        chk("t4_state_run", 32'(state),      32'd1);
        chk("t4_rc_clear",  32'(run_cycles), 32'd0);
        idle(5);
        #1;
        chk("t4_rc_count",  32'(run_cycles), 32'd5);

        // reset one cycle after a granted CPU read
        step(1, 0, 8'd7, 16'h0, 0, 0, 8'h0, 16'h0, 0, 0);
        #2;
        rst = 1;
        rst_lvl = 1;
        #1;
        model_reset();
        chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("t5_cpu_gnt",    32'(cpu_gnt),    32'd0);
        chk("t5_state",      32'(state),      32'd0);
        chk("t5_cpu_run",    32'(cpu_run),    32'd0);
        chk("t5_mem_addr",   32'(mem_addr),   32'd0);
        chk("t5_mem_we",     32'(mem_we),     32'd0);
        chk("t5_cpu_rdata",  32'(cpu_rdata),  32'd0);
        chk("t5_run_cycles", 32'(run_cycles), 32'd0);
        idle(3);
        rst_lvl = 0;
        host_rd(8'd50);
        idle(3);

        // saturation
        step(0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 1, 0);
        idle(70000);
        chk("t6_sat", 32'(run_cycles), 32'hFFFF);
        step(0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, 1);
        idle(3);
        chk("t6_hold", 32'(run_cycles), 32'hFFFF);
        chk("t6_state", 32'(state), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single-port 256×16 program/data BRAM shared by `CPU_top` and a host loader port. It owns three phases:
- **LOAD**: the host writes the program while the CPU is held in reset.
- **RUN**: the CPU executes, and host accesses are interleaved round-robin.
- **HALTED**: the CPU is held again and the host reads results.

It sits between the CPU memory port, the host/test interface and the BRAM.

## Interface
Parameters:
- `AW`, 8: address width.
- `DW`, 16: data width.
- `RD_LAT`, 1: BRAM read latency in cycles. Legal values are 1 or 2.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req`, `cpu_we` in 1 each: CPU access request and write enable.
- `cpu_addr` in AW; `cpu_wdata` in DW: CPU address and write data.
- `cpu_gnt` out 1: CPU access accepted this cycle (combinational).
- `cpu_rvalid` out 1; `cpu_rdata` out DW: CPU read return.
- `cpu_halt` in 1: CPU has executed HALT (level).
- `cpu_run` out 1: CPU run enable; low holds the CPU in reset (drives the CPU `rst_n`).
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`, `host_rdata`: same semantics as the CPU port, for the host.
- `host_start` in 1: pulse; start or restart the program.
- `mem_addr` out AW; `mem_din` out DW; `mem_we` out 1: BRAM request side.
- `mem_dout` in DW: BRAM read data, valid `RD_LAT` cycles after the address.
- `state` out 2: 0 = LOAD, 1 = RUN, 2 = HALTED.
- `run_cycles` out 16: count of cycles spent in RUN.

## Operation
FSM transitions:
- LOAD → RUN on `host_start`.
- RUN → HALTED on `cpu_halt`.
- HALTED → RUN on `host_start`, which restarts the CPU from PC 0 because `cpu_run` was low.
- `host_start` is ignored in RUN.
- If `host_start` and `cpu_halt` are asserted together in RUN, HALTED wins.
- `cpu_halt` is ignored outside RUN.

Outputs per state:
- `cpu_run` = 1 only in RUN (registered, follows `state`).
- In LOAD and HALTED, only the host can be granted: `cpu_gnt` = 0 and `cpu_req` is ignored.

Arbitration in RUN:
- A single request is granted alone.
- When both request, grant the requester not granted last; a `last` register tracks this.
- `last` resets to HOST, so the CPU wins the first conflict.
- `last` updates only on a grant.
- Exactly one grant per cycle.

Memory drive:
- `mem_addr` and `mem_din` carry the granted requester's address and data.
- `mem_we` = grant & that requester's `we`.
- When nothing is granted: `mem_we` = 0 and `mem_addr`/`mem_din` hold their last values (registered shadow).

Read return:
- Each granted read pushes an owner tag into an `RD_LAT`-deep shift pipeline.
- At the output end, the owner's `rvalid` pulses for 1 cycle and its `rdata` = `mem_dout`.
- Writes produce no `rvalid`.
- The non-owner's `rdata` holds its previous value.

`run_cycles`:
- Cleared to 0 on the cycle of entering RUN.
- Increments every RUN cycle and saturates at 0xFFFF.
- Holds its value in HALTED and LOAD.

## Timing
- Reset values: `state` = LOAD, `cpu_run` = 0, `cpu_gnt` = `host_gnt` = 0, both `rvalid` = 0, both `rdata` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0, `run_cycles` = 0, `last` = HOST, read pipeline empty.
- Grant is combinational in the request cycle. The BRAM write occurs at the edge closing that cycle.
- Read data arrives with `rvalid` exactly `RD_LAT` cycles after the grant cycle.
- Back-to-back reads (one per cycle) are fully pipelined with no bubbles.
- State change: `host_start` sampled at edge N means `state`/`cpu_run` change after edge N. The CPU's first access can be granted in cycle N+1.
- Halt: `cpu_halt` sampled at edge N drops `cpu_run` after edge N, and `cpu_gnt` is 0 from then on. CPU reads already in flight still return their `rvalid`.
- Reset asserted mid-operation: all outputs go to reset values immediately and asynchronously, and in-flight `rvalid`s are dropped. Memory contents are untouched.

## Test plan
1. **LOAD phase.** Stimulus: reset; host writes 0x0232 to address 0 and 0x0001 to address 50 while `cpu_req` = 1 constantly. Required: `cpu_gnt` = 0 throughout; `host_gnt` = 1 on each write; host read of address 50 returns 0x0001 with `host_rvalid` exactly `RD_LAT` cycles later.
2. **Start/halt.** Stimulus: `host_start` pulse, CPU runs the program, `cpu_halt` is asserted after 40 RUN cycles. Required: `cpu_run` 0→1 the cycle after start; `state` = 2; `cpu_run` = 0; `run_cycles` = 40 and holds.
3. **RUN conflict.** Stimulus: `cpu_req` and `host_req` both held for 4 cycles, reading addresses 10 and 20. Required: grants in the order CPU, HOST, CPU, HOST; `mem_addr` = 10, 20, 10, 20; each owner's `rvalid` is correctly tagged.
4. **Simultaneous events.** Stimulus: `host_start` and `cpu_halt` in the same RUN cycle. Required: `state` goes to HALTED. Then `host_start` in HALTED: `state` = RUN, `run_cycles` = 0 and counts again.
5. **Reset mid-read.** Stimulus: with `RD_LAT` = 2, `rst` is asserted one cycle after a granted CPU read. Required: `cpu_rvalid` never pulses; all outputs are at reset values; `state` = LOAD.
6. **Saturation.** Stimulus: stay in RUN for 70000 cycles. Required: `run_cycles` = 0xFFFF and holds.
